// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle LC-3-style core: opcodes, FSM states,
// condition-code bit positions and small decode helpers.
package cpu_pkg;

  localparam int NUM_REGS = 8;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] r);
    logic [2:0] c;
    c        = '0;
    c[NZP_N] = r[15];
    c[NZP_Z] = (r == 16'h0000);
    c[NZP_P] = !r[15] && (r != 16'h0000);
    return c;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x16 general-purpose register file: two asynchronous read ports, one
// synchronous write port, cleared asynchronously on rst_n.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd1,
  output logic [15:0] rd2,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd
);

  logic [15:0] regs [NUM_REGS];

  // NOTE: only eight words, and software relies on R0..R7 reading zero after
  // reset, so this array takes the async clear; large memories normally don't.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/cpu_core_mc.sv
// Multicycle 16-bit LC-3-style core: FETCH/DECODE/EXEC/MEM/HALT sequencing over
// one shared req/ready memory port with registered request outputs.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int          ADDR_W       = 16,
  parameter logic [15:0] RESET_PC     = 16'h3000,
  parameter bit          HALT_ON_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       pc_out,
  output logic [2:0]        nzp,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  state_e state, state_next;

  logic [15:0]       pc, pc_next, ir, ir_next;
  logic [2:0]        nzp_next;
  logic              illegal_next;
  logic              req_next, we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [15:0]       wdata_next;

  logic              rf_we;
  logic [2:0]        rf_wa;
  logic [15:0]       rf_wd, rd1, rd2;

  opcode_e           op;
  logic [2:0]        sr2;
  logic              is_load, is_store;
  logic [15:0]       alu_b, alu_res, pc_rel, ea;
  logic              fetch_go;
  logic [15:0]       fetch_pc;

  // Decode is purely combinational from IR; IR is stable from DECODE through MEM.
  assign op       = opcode_e'(ir[15:12]);
  assign is_load  = (op == OP_LD) || (op == OP_LDR);
  assign is_store = (op == OP_ST) || (op == OP_STR);
  assign sr2      = is_store ? ir[11:9] : ir[2:0];
  assign pc_rel   = pc + sext9(ir[8:0]);
  assign ea       = ((op == OP_LDR) || (op == OP_STR)) ? rd1 + sext6(ir[5:0]) : pc_rel;
  assign alu_b    = ir[5] ? sext5(ir[4:0]) : rd2;

  always_comb begin
    alu_res = rd1 + alu_b;
    case (op)
      OP_AND:  alu_res = rd1 & alu_b;
      OP_NOT:  alu_res = ~rd1;
      default: alu_res = rd1 + alu_b;
    endcase
  end

  cpu_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ir[8:6]),
    .ra2   (sr2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // NOTE: every signal driven below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    nzp_next     = nzp;
    illegal_next = illegal;
    req_next     = mem_req && !mem_ready;
    we_next      = mem_we;
    addr_next    = mem_addr;
    wdata_next   = mem_wdata;
    rf_we        = 1'b0;
    rf_wa        = ir[11:9];
    rf_wd        = alu_res;
    retire       = 1'b0;
    fetch_go     = 1'b0;
    fetch_pc     = pc;

    case (state)
      S_FETCH: begin
        if (!mem_req) begin
          req_next  = 1'b1;
          we_next   = 1'b0;
          addr_next = pc[ADDR_W-1:0];
        end else if (mem_ready) begin
          ir_next    = mem_rdata;
          pc_next    = pc + 16'd1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: state_next = S_EXEC;

      S_EXEC: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_we    = 1'b1;
            nzp_next = nzp_of(alu_res);
            fetch_go = 1'b1;
          end
          OP_BR: begin
            if ((ir[11:9] & nzp) != 3'b000) fetch_pc = pc_rel;
            fetch_go = 1'b1;
          end
          OP_JMP: begin
            fetch_pc = rd1;
            fetch_go = 1'b1;
          end
          OP_LEA: begin
            rf_we    = 1'b1;
            rf_wd    = pc_rel;
            fetch_go = 1'b1;
          end
          OP_LD, OP_LDR, OP_ST, OP_STR: begin
            req_next   = 1'b1;
            we_next    = is_store;
            addr_next  = ea[ADDR_W-1:0];
            wdata_next = rd2;
            state_next = S_MEM;
          end
          OP_TRAP: begin
            if (HALT_ON_TRAP) state_next = S_HALT;
            else              fetch_go   = 1'b1;
          end
          default: begin
            illegal_next = 1'b1;
            fetch_go     = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        if (mem_ready) begin
          if (is_load) begin
            rf_we    = 1'b1;
            rf_wd    = mem_rdata;
            nzp_next = nzp_of(mem_rdata);
          end
          fetch_go = 1'b1;
        end
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_FETCH;
    endcase

    // Retiring instructions issue the next fetch on the same edge, so the
    // FETCH cycle already presents the request.
    if (fetch_go) begin
      retire     = 1'b1;
      pc_next    = fetch_pc;
      req_next   = 1'b1;
      we_next    = 1'b0;
      addr_next  = fetch_pc[ADDR_W-1:0];
      state_next = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ir        <= '0;
      nzp       <= 3'b010;
      illegal   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      pc        <= pc_next;
      ir        <= ir_next;
      nzp       <= nzp_next;
      illegal   <= illegal_next;
      mem_req   <= req_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
    end
  end

  assign pc_out = pc;
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: a small program in a unified memory model
// with programmable wait states on the 16'h31xx data page.
module tb_cpu_core_mc;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, retire, halted, illegal;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [2:0]  nzp;

  logic [15:0] mem [0:65535];
  int          wcnt, need, data_wait;
  bit          stall_all;
  int          n_cmp, n_bad;

  cpu_core_mc #(.ADDR_W(16), .RESET_PC(16'h3000), .HALT_ON_TRAP(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .pc_out    (pc_out),
    .nzp       (nzp),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: data page 31xx gets data_wait wait states.
  assign need      = (mem_addr[15:8] == 8'h31) ? data_wait : 0;
  assign mem_ready = mem_req && !stall_all && (wcnt >= need);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (mem_req && mem_ready) wcnt <= 0;
    else if (mem_req) wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic wait_retire(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 40);
    if (!retire) begin
      n_cmp++; n_bad++;
      $display("FAIL retire_timeout: no retire after %0d cycles", n);
    end
  endtask

  task automatic finish_instr();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    if (!mem_req) begin
      n_cmp++; n_bad++;
      $display("FAIL req_timeout: no mem_req after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    stall_all = 0;
    data_wait = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_addr: got %h want 0000", mem_addr); end
    n_cmp++; if (mem_wdata !== 16'h0000) begin n_bad++; $display("FAIL rst_wdata: got %h want 0000", mem_wdata); end
    n_cmp++; if (pc_out !== 16'h3000) begin n_bad++; $display("FAIL rst_pc: got %h want 3000", pc_out); end
    n_cmp++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL rst_nzp: got %b want 010", nzp); end
    n_cmp++; if ({retire, halted, illegal} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {retire, halted, illegal}); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int n;
    wait_req(n);
    n_cmp++; if (mem_addr !== 16'h3000) begin n_bad++; $display("FAIL first_fetch_addr: got %h want 3000", mem_addr); end
    n = 1;
    while (!retire && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL add_latency: got %0d want 3", n); end
    finish_instr();
    n_cmp++; if (dut.u_rf.regs[1] !== 16'h0005) begin n_bad++; $display("FAIL add_r1: got %h want 0005", dut.u_rf.regs[1]); end
    n_cmp++; if (nzp !== 3'b001) begin n_bad++; $display("FAIL add_nzp: got %b want 001", nzp); end
  endtask

  task automatic test_branch_taken();
    int n;
    wait_retire(n);
    finish_instr();
    n_cmp++; if (dut.u_rf.regs[2] !== 16'h0000) begin n_bad++; $display("FAIL and_r2: got %h want 0000", dut.u_rf.regs[2]); end
    n_cmp++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL and_nzp: got %b want 010", nzp); end
    wait_retire(n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL br_latency: got %0d want 3", n); end
    finish_instr();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h3005) begin n_bad++; $display("FAIL brz_target: got req=%b addr=%h want req=1 addr=3005", mem_req, mem_addr); end
    n_cmp++; if (pc_out !== 16'h3005) begin n_bad++; $display("FAIL brz_pc: got %h want 3005", pc_out); end
  endtask

  task automatic test_load_wait();
    int n;
    data_wait = 3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n >= 4) begin
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h3100 || mem_we !== 1'b0) begin
          n_bad++;
          $display("FAIL ld_hold_c%0d: got req=%b addr=%h we=%b want req=1 addr=3100 we=0", n, mem_req, mem_addr, mem_we);
        end
      end
    end while (!retire && n < 20);
    n_cmp++; if (n !== 7 || retire !== 1'b1) begin n_bad++; $display("FAIL ld_latency: got %0d want 7", n); end
    data_wait = 0;
    finish_instr();
    n_cmp++; if (dut.u_rf.regs[3] !== 16'h8000) begin n_bad++; $display("FAIL ld_r3: got %h want 8000", dut.u_rf.regs[3]); end
    n_cmp++; if (nzp !== 3'b100) begin n_bad++; $display("FAIL ld_nzp: got %b want 100", nzp); end
  endtask

  task automatic test_store_load();
    int  n;
    bit  seen;
    seen = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req && mem_we && !seen) begin
        seen = 1;
        n_cmp++;
        if (mem_addr !== 16'h3101 || mem_wdata !== 16'h8000) begin
          n_bad++;
          $display("FAIL st_req: got addr=%h wdata=%h want addr=3101 wdata=8000", mem_addr, mem_wdata);
        end
      end
    end while (!retire && n < 20);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL st_we: got no write request want mem_we=1"); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL st_latency: got %0d want 4", n); end
    finish_instr();
    n_cmp++; if (mem[16'h3101] !== 16'h8000) begin n_bad++; $display("FAIL st_mem: got %h want 8000", mem[16'h3101]); end
    wait_retire(n);
    finish_instr();
    n_cmp++; if (dut.u_rf.regs[4] !== 16'h8000) begin n_bad++; $display("FAIL ld_r4: got %h want 8000", dut.u_rf.regs[4]); end
  endtask

  task automatic test_not_lea_jmp();
    int n;
    wait_retire(n);
    finish_instr();
    n_cmp++; if (dut.u_rf.regs[5] !== 16'h7FFF) begin n_bad++; $display("FAIL not_r5: got %h want 7fff", dut.u_rf.regs[5]); end
    n_cmp++; if (nzp !== 3'b001) begin n_bad++; $display("FAIL not_nzp: got %b want 001", nzp); end
    wait_retire(n);
    finish_instr();
    n_cmp++; if (dut.u_rf.regs[6] !== 16'h300D) begin n_bad++; $display("FAIL lea_r6: got %h want 300d", dut.u_rf.regs[6]); end
    n_cmp++; if (nzp !== 3'b001) begin n_bad++; $display("FAIL lea_nzp: got %b want 001", nzp); end
    wait_retire(n);
    finish_instr();
    n_cmp++; if (mem_addr !== 16'h300D) begin n_bad++; $display("FAIL jmp_target: got %h want 300d", mem_addr); end
  endtask

  task automatic test_illegal_trap();
    int n;
    int reqs;
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_pre: got %b want 0", illegal); end
    wait_retire(n);
    finish_instr();
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_set: got %b want 1", illegal); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 20);
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL trap_halt: got %b want 1", halted); end
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b0) reqs++;
    end
    n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL halt_no_req: got %0d request cycles want 0", reqs); end
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
  endtask

  task automatic test_branch_not_taken();
    int n;
    mem[16'h3002] = 16'h0802;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) wait_retire(n);
    finish_instr();
    n_cmp++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL brn_pre_nzp: got %b want 010", nzp); end
    wait_retire(n);
    finish_instr();
    n_cmp++; if (mem_addr !== 16'h3003) begin n_bad++; $display("FAIL brn_fallthrough: got %h want 3003", mem_addr); end
  endtask

  task automatic test_reset_mid();
    int n;
    stall_all = 1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(n);
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL stall_req: got %b want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL async_req_drop: got %b want 0", mem_req); end
    @(negedge clk);
    stall_all = 0;
    rst_n = 1'b1;
    wait_req(n);
    n_cmp++; if (mem_addr !== 16'h3000) begin n_bad++; $display("FAIL restart_addr: got %h want 3000", mem_addr); end
    n_cmp++; if (nzp !== 3'b010 || halted !== 1'b0) begin n_bad++; $display("FAIL restart_state: got nzp=%b halted=%b want nzp=010 halted=0", nzp, halted); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    stall_all = 0;
    data_wait = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hF025;
    mem[16'h3000] = 16'h1225;  // ADD R1,R0,#5
    mem[16'h3001] = 16'h5460;  // AND R2,R1,#0
    mem[16'h3002] = 16'h0402;  // BRz +2
    mem[16'h3005] = 16'h26FA;  // LD  R3 <- [3100]
    mem[16'h3006] = 16'h36FA;  // ST  R3 -> [3101]
    mem[16'h3007] = 16'h28F9;  // LD  R4 <- [3101]
    mem[16'h3008] = 16'h9B3F;  // NOT R5,R4
    mem[16'h3009] = 16'hEC03;  // LEA R6,#3
    mem[16'h300A] = 16'hC180;  // JMP R6
    mem[16'h300D] = 16'hD000;  // reserved opcode
    mem[16'h300E] = 16'hF025;  // TRAP
    mem[16'h3100] = 16'h8000;

    test_reset();
    test_add();
    test_branch_taken();
    test_load_wait();
    test_store_load();
    test_not_lea_jmp();
    test_illegal_trap();
    test_branch_not_taken();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
